// File: rtl/mem_arb_pkg.sv
// Shared types for the IF/MEM unified-memory arbiter: FSM states, grant encoding, fill data.
// Types and constants only; no timing or backpressure of its own.
// The helper function encodes the fixed data-over-fetch priority.
package mem_arb_pkg;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;

    // Read data returned on a timed-out load (MEM_ARB_TIMEOUT_EN builds only)
    localparam logic [31:0] DEAD_BEEF = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DACC = 2'd1,
        IACC = 2'd2,
        DONE = 2'd3
    } arb_state_e;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_IF   = 2'd1,
        GNT_DM   = 2'd2
    } arb_gnt_e;

    // MEM holds the older instruction, so it always wins a tie
    function automatic arb_gnt_e arb_pick(input logic if_req, input logic dm_req);
        if (dm_req) return GNT_DM;
        if (if_req) return GNT_IF;
        return GNT_NONE;
    endfunction

endpackage

// File: rtl/mem_arb_timeout_cnt.sv
// Wait-cycle counter for an outstanding memory access; flags expiry on its TIMEOUT-th cycle.
// Latency: o_expire is combinational from the count; the count advances one per enabled cycle.
// No backpressure; the count saturates at TIMEOUT-1 until cleared.
module mem_arb_timeout_cnt #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expire
);

    localparam int unsigned CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n || i_clr) begin
            r_cnt <= '0;
        end else if (i_en && (r_cnt != LAST)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_expire = i_en && (r_cnt == LAST);

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises IF fetches and MEM loads/stores onto one req/ack memory port (MEM_ARB_TIMEOUT_EN adds a timeout).
// Latency: mem_req_o one cycle after a request, ready one cycle after mem_ack_i, then a one-cycle bubble.
// Backpressure: stall_o holds the pipeline while either requester is waiting for its ready pulse.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int          ADDR_W  = DEF_ADDR_W,
    parameter int          DATA_W  = DEF_DATA_W,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic [DATA_W-1:0] if_rdata_o,
    output logic              if_ready_o,
    input  logic              dm_req_i,
    input  logic              dm_we_i,
    input  logic [ADDR_W-1:0] dm_addr_i,
    input  logic [DATA_W-1:0] dm_wdata_i,
    output logic [DATA_W-1:0] dm_rdata_o,
    output logic              dm_ready_o,
    output logic              stall_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    input  logic              mem_ack_i,
    output logic              err_o
);

    if (TIMEOUT < 2) begin : g_bad_timeout
        $error("mem_port_arbiter: TIMEOUT must be at least 2");
    end

    arb_state_e        r_state, w_state_nxt;
    arb_gnt_e          w_gnt;
    logic              r_mem_req, w_mem_req_nxt;
    logic              r_mem_we, w_mem_we_nxt;
    logic [ADDR_W-1:0] r_mem_addr, w_mem_addr_nxt;
    logic [DATA_W-1:0] r_mem_wdata, w_mem_wdata_nxt;
    logic [DATA_W-1:0] r_if_rdata, w_if_rdata_nxt;
    logic [DATA_W-1:0] r_dm_rdata, w_dm_rdata_nxt;
    logic              r_if_ready, w_if_ready_nxt;
    logic              r_dm_ready, w_dm_ready_nxt;
    logic              r_err, w_err_nxt;
    logic              w_to_expire;
    logic [DATA_W-1:0] w_fill;

`ifdef MEM_ARB_TIMEOUT_EN
    // Counter restarts whenever the FSM is outside an access, i.e. on entry to DACC/IACC
    mem_arb_timeout_cnt #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout_cnt (
        .i_clk    (clk_i),
        .i_rst_n  (rst_n_i),
        .i_clr    ((r_state != DACC) && (r_state != IACC)),
        .i_en     ((r_state == DACC) || (r_state == IACC)),
        .o_expire (w_to_expire)
    );
    assign w_fill = DATA_W'(DEAD_BEEF);
`else
    assign w_to_expire = 1'b0;
    assign w_fill      = '0;
`endif

    always_comb begin
        w_state_nxt     = r_state;
        w_gnt           = GNT_NONE;
        w_mem_req_nxt   = r_mem_req;
        w_mem_we_nxt    = r_mem_we;
        w_mem_addr_nxt  = r_mem_addr;
        w_mem_wdata_nxt = r_mem_wdata;
        w_if_rdata_nxt  = r_if_rdata;
        w_dm_rdata_nxt  = r_dm_rdata;
        w_if_ready_nxt  = 1'b0;
        w_dm_ready_nxt  = 1'b0;
        w_err_nxt       = r_err;

        case (r_state)
            IDLE: begin
                w_gnt = arb_pick(if_req_i, dm_req_i);
                case (w_gnt)
                    GNT_DM: begin
                        w_mem_req_nxt   = 1'b1;
                        w_mem_we_nxt    = dm_we_i;
                        w_mem_addr_nxt  = dm_addr_i;
                        w_mem_wdata_nxt = dm_wdata_i;
                        w_state_nxt     = DACC;
                    end
                    GNT_IF: begin
                        w_mem_req_nxt  = 1'b1;
                        w_mem_we_nxt   = 1'b0;
                        w_mem_addr_nxt = if_addr_i;
                        w_state_nxt    = IACC;
                    end
                    default: ;
                endcase
            end
            DACC, IACC: begin
                // An ack coinciding with expiry takes precedence over the timeout
                if (mem_ack_i || w_to_expire) begin
                    w_mem_req_nxt = 1'b0;
                    w_err_nxt     = r_err | ~mem_ack_i;
                    w_state_nxt   = DONE;
                    if (r_state == DACC) begin
                        w_dm_ready_nxt = 1'b1;
                        if (!r_mem_we) begin
                            w_dm_rdata_nxt = mem_ack_i ? mem_rdata_i : w_fill;
                        end
                    end else begin
                        w_if_ready_nxt = 1'b1;
                        w_if_rdata_nxt = mem_ack_i ? mem_rdata_i : w_fill;
                    end
                end
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_state     <= IDLE;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_if_rdata  <= '0;
            r_dm_rdata  <= '0;
            r_if_ready  <= 1'b0;
            r_dm_ready  <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_mem_req   <= w_mem_req_nxt;
            r_mem_we    <= w_mem_we_nxt;
            r_mem_addr  <= w_mem_addr_nxt;
            r_mem_wdata <= w_mem_wdata_nxt;
            r_if_rdata  <= w_if_rdata_nxt;
            r_dm_rdata  <= w_dm_rdata_nxt;
            r_if_ready  <= w_if_ready_nxt;
            r_dm_ready  <= w_dm_ready_nxt;
            r_err       <= w_err_nxt;
        end
    end

    assign mem_req_o   = r_mem_req;
    assign mem_we_o    = r_mem_we;
    assign mem_addr_o  = r_mem_addr;
    assign mem_wdata_o = r_mem_wdata;
    assign if_rdata_o  = r_if_rdata;
    assign dm_rdata_o  = r_dm_rdata;
    assign if_ready_o  = r_if_ready;
    assign dm_ready_o  = r_dm_ready;
    assign err_o       = r_err;
    assign stall_o     = (if_req_i & ~r_if_ready) | (dm_req_i & ~r_dm_ready);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: fetch, data/fetch tie, store, reset mid-access, stray ack,
// and (with MEM_ARB_TIMEOUT_EN, TIMEOUT=8) a load that times out.
module tb_mem_port_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk_i = 1'b0;
    logic          rst_n_i;
    logic          if_req_i;
    logic [AW-1:0] if_addr_i;
    logic [DW-1:0] if_rdata_o;
    logic          if_ready_o;
    logic          dm_req_i;
    logic          dm_we_i;
    logic [AW-1:0] dm_addr_i;
    logic [DW-1:0] dm_wdata_i;
    logic [DW-1:0] dm_rdata_o;
    logic          dm_ready_o;
    logic          stall_o;
    logic          mem_req_o;
    logic          mem_we_o;
    logic [AW-1:0] mem_addr_o;
    logic [DW-1:0] mem_wdata_o;
    logic [DW-1:0] mem_rdata_i;
    logic          mem_ack_i;
    logic          err_o;

    int n_vec = 0;
    int n_err = 0;

    mem_port_arbiter #(
        .ADDR_W  (AW),
        .DATA_W  (DW),
        .TIMEOUT (8)
    ) dut (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .if_req_i    (if_req_i),
        .if_addr_i   (if_addr_i),
        .if_rdata_o  (if_rdata_o),
        .if_ready_o  (if_ready_o),
        .dm_req_i    (dm_req_i),
        .dm_we_i     (dm_we_i),
        .dm_addr_i   (dm_addr_i),
        .dm_wdata_i  (dm_wdata_i),
        .dm_rdata_o  (dm_rdata_o),
        .dm_ready_o  (dm_ready_o),
        .stall_o     (stall_o),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_rdata_i (mem_rdata_i),
        .mem_ack_i   (mem_ack_i),
        .err_o       (err_o)
    );

    always #5 clk_i = ~clk_i;

    // Inputs change 1 time unit after the rising edge; checks run 4 units after it.
    task automatic next_cycle();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n_i     = 1'b0;
        if_req_i    = 1'b0;
        if_addr_i   = '0;
        dm_req_i    = 1'b0;
        dm_we_i     = 1'b0;
        dm_addr_i   = '0;
        dm_wdata_i  = '0;
        mem_rdata_i = '0;
        mem_ack_i   = 1'b0;

        // ---- reset ----
        next_cycle();
        next_cycle();
        #3;
        chk("rst_mem_req", 32'(mem_req_o), 32'd0);
        chk("rst_mem_we", 32'(mem_we_o), 32'd0);
        chk("rst_mem_addr", mem_addr_o, 32'h0);
        chk("rst_mem_wdata", mem_wdata_o, 32'h0);
        chk("rst_if_ready", 32'(if_ready_o), 32'd0);
        chk("rst_dm_ready", 32'(dm_ready_o), 32'd0);
        chk("rst_if_rdata", if_rdata_o, 32'h0);
        chk("rst_dm_rdata", dm_rdata_o, 32'h0);
        chk("rst_err", 32'(err_o), 32'd0);
        chk("rst_stall", 32'(stall_o), 32'd0);
        next_cycle();
        rst_n_i = 1'b1;

        // ---- fetch only, ack one cycle after mem_req_o ----
        next_cycle();                               // cycle 0
        if_req_i = 1'b1; if_addr_i = 32'h0000_0010;
        #3;
        chk("f_c0_stall", 32'(stall_o), 32'd1);
        chk("f_c0_mem_req", 32'(mem_req_o), 32'd0);
        next_cycle();                               // cycle 1
        #3;
        chk("f_c1_mem_req", 32'(mem_req_o), 32'd1);
        chk("f_c1_mem_addr", mem_addr_o, 32'h0000_0010);
        chk("f_c1_mem_we", 32'(mem_we_o), 32'd0);
        chk("f_c1_stall", 32'(stall_o), 32'd1);
        next_cycle();                               // cycle 2
        mem_ack_i = 1'b1; mem_rdata_i = 32'h8C08_0004;
        #3;
        chk("f_c2_stall", 32'(stall_o), 32'd1);
        chk("f_c2_if_ready", 32'(if_ready_o), 32'd0);
        next_cycle();                               // cycle 3
        mem_ack_i = 1'b0; mem_rdata_i = 32'h0;
        #3;
        chk("f_c3_if_ready", 32'(if_ready_o), 32'd1);
        chk("f_c3_if_rdata", if_rdata_o, 32'h8C08_0004);
        chk("f_c3_stall", 32'(stall_o), 32'd0);
        chk("f_c3_mem_req", 32'(mem_req_o), 32'd0);
        chk("f_c3_dm_ready", 32'(dm_ready_o), 32'd0);
        next_cycle();                               // cycle 4
        if_req_i = 1'b0;
        #3;
        chk("f_c4_if_ready", 32'(if_ready_o), 32'd0);

        // ---- simultaneous data load and fetch, ack latency 0 ----
        next_cycle();                               // cycle 0
        dm_req_i = 1'b1; dm_we_i = 1'b0; dm_addr_i = 32'h0000_0100;
        if_req_i = 1'b1; if_addr_i = 32'h0000_0014;
        next_cycle();                               // cycle 1
        mem_ack_i = 1'b1; mem_rdata_i = 32'h1111_2222;
        #3;
        chk("s_c1_mem_req", 32'(mem_req_o), 32'd1);
        chk("s_c1_mem_addr", mem_addr_o, 32'h0000_0100);
        chk("s_c1_mem_we", 32'(mem_we_o), 32'd0);
        next_cycle();                               // cycle 2
        mem_ack_i = 1'b0; mem_rdata_i = 32'h0;
        #3;
        chk("s_c2_dm_ready", 32'(dm_ready_o), 32'd1);
        chk("s_c2_dm_rdata", dm_rdata_o, 32'h1111_2222);
        chk("s_c2_if_ready", 32'(if_ready_o), 32'd0);
        chk("s_c2_stall", 32'(stall_o), 32'd1);
        next_cycle();                               // cycle 3 (bubble)
        dm_req_i = 1'b0;
        #3;
        chk("s_c3_dm_ready", 32'(dm_ready_o), 32'd0);
        chk("s_c3_mem_req", 32'(mem_req_o), 32'd0);
        next_cycle();                               // cycle 4
        mem_ack_i = 1'b1; mem_rdata_i = 32'h3333_4444;
        #3;
        chk("s_c4_mem_req", 32'(mem_req_o), 32'd1);
        chk("s_c4_mem_addr", mem_addr_o, 32'h0000_0014);
        next_cycle();                               // cycle 5
        mem_ack_i = 1'b0; mem_rdata_i = 32'h0;
        #3;
        chk("s_c5_if_ready", 32'(if_ready_o), 32'd1);
        chk("s_c5_if_rdata", if_rdata_o, 32'h3333_4444);
        chk("s_c5_dm_rdata_hold", dm_rdata_o, 32'h1111_2222);
        next_cycle();                               // cycle 6
        if_req_i = 1'b0;

        // ---- store with 5 wait cycles ----
        next_cycle();                               // cycle 0
        dm_req_i = 1'b1; dm_we_i = 1'b1; dm_addr_i = 32'h0000_0200; dm_wdata_i = 32'h0000_00AB;
        mem_rdata_i = 32'hFFFF_FFFF;
        for (int c = 1; c <= 5; c++) begin
            next_cycle();
            #3;
            chk($sformatf("st_c%0d_mem_req", c), 32'(mem_req_o), 32'd1);
            chk($sformatf("st_c%0d_mem_we", c), 32'(mem_we_o), 32'd1);
            chk($sformatf("st_c%0d_mem_wdata", c), mem_wdata_o, 32'h0000_00AB);
            chk($sformatf("st_c%0d_mem_addr", c), mem_addr_o, 32'h0000_0200);
            chk($sformatf("st_c%0d_dm_ready", c), 32'(dm_ready_o), 32'd0);
        end
        next_cycle();                               // cycle 6
        mem_ack_i = 1'b1; mem_rdata_i = 32'h5555_AAAA;
        next_cycle();                               // cycle 7
        mem_ack_i = 1'b0;
        #3;
        chk("st_c7_dm_ready", 32'(dm_ready_o), 32'd1);
        chk("st_c7_dm_rdata_hold", dm_rdata_o, 32'h1111_2222);
        chk("st_c7_mem_req", 32'(mem_req_o), 32'd0);
        next_cycle();                               // cycle 8
        dm_req_i = 1'b0; dm_we_i = 1'b0;
        #3;
        chk("st_c8_dm_ready", 32'(dm_ready_o), 32'd0);
        chk("st_c8_err", 32'(err_o), 32'd0);

        // ---- reset while in IACC, then a late ack ----
        next_cycle();                               // cycle 0
        if_req_i = 1'b1; if_addr_i = 32'h0000_0040;
        next_cycle();                               // cycle 1
        #3;
        chk("r_c1_mem_req", 32'(mem_req_o), 32'd1);
        chk("r_c1_mem_addr", mem_addr_o, 32'h0000_0040);
        next_cycle();                               // cycle 2
        rst_n_i = 1'b0;
        next_cycle();                               // cycle 3
        rst_n_i = 1'b1; if_req_i = 1'b0;
        mem_ack_i = 1'b1; mem_rdata_i = 32'h7777_8888;
        #3;
        chk("r_c3_mem_req", 32'(mem_req_o), 32'd0);
        chk("r_c3_if_ready", 32'(if_ready_o), 32'd0);
        next_cycle();                               // cycle 4
        mem_ack_i = 1'b0;
        #3;
        chk("r_c4_if_ready", 32'(if_ready_o), 32'd0);
        chk("r_c4_if_rdata", if_rdata_o, 32'h0);
        chk("r_c4_mem_req", 32'(mem_req_o), 32'd0);

        // ---- stray ack in IDLE ----
        next_cycle();
        mem_ack_i = 1'b1; mem_rdata_i = 32'h1234_5678;
        next_cycle();
        mem_ack_i = 1'b0;
        #3;
        chk("sa_if_ready", 32'(if_ready_o), 32'd0);
        chk("sa_dm_ready", 32'(dm_ready_o), 32'd0);
        chk("sa_if_rdata", if_rdata_o, 32'h0);
        chk("sa_dm_rdata", dm_rdata_o, 32'h0);
        chk("sa_mem_req", 32'(mem_req_o), 32'd0);
        chk("sa_err", 32'(err_o), 32'd0);

`ifdef MEM_ARB_TIMEOUT_EN
        // ---- load with no ack: expires after 8 wait cycles ----
        next_cycle();                               // cycle 0
        dm_req_i = 1'b1; dm_we_i = 1'b0; dm_addr_i = 32'h0000_0300;
        for (int c = 1; c <= 8; c++) begin
            next_cycle();
            #3;
            chk($sformatf("to_c%0d_mem_req", c), 32'(mem_req_o), 32'd1);
            chk($sformatf("to_c%0d_dm_ready", c), 32'(dm_ready_o), 32'd0);
            chk($sformatf("to_c%0d_err", c), 32'(err_o), 32'd0);
        end
        next_cycle();                               // cycle 9
        #3;
        chk("to_c9_dm_ready", 32'(dm_ready_o), 32'd1);
        chk("to_c9_dm_rdata", dm_rdata_o, 32'hDEAD_BEEF);
        chk("to_c9_err", 32'(err_o), 32'd1);
        chk("to_c9_mem_req", 32'(mem_req_o), 32'd0);
        next_cycle();                               // cycle 10
        dm_req_i = 1'b0;
        next_cycle();
        next_cycle();
        #3;
        chk("to_err_sticky", 32'(err_o), 32'd1);
        next_cycle();
        rst_n_i = 1'b0;
        next_cycle();
        rst_n_i = 1'b1;
        #3;
        chk("to_err_cleared", 32'(err_o), 32'd0);
`endif

        next_cycle();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Hard stop in case the sequence above ever stalls
    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
